ahb_slave_mux_n: RTL

Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for N slaves, with a built-in default slave. It sits between the single AHB master and the slave array. It decodes haddr into one-hot hsel, registers the data-phase selection only when the bus is ready, and muxes hrdata/hready/hresp back to the master. Unmapped active transfers receive the protocol-correct two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_default_slave.sv | 63 ++++++
 rtl/ahb_slave_mux_n.sv | 89 ++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the default-slave state type used by the
// slave mux and its built-in error responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle ERROR
// response (ERR1 stalls, ERR2 completes) and everything else with OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic      hclk,
  input  logic      hreset,
  input  logic      hready,
  input  logic      i_err_req,
  output logic      o_hready,
  output logic      o_hresp,
  output ds_state_t o_state
);

  ds_state_t r_state;
  logic      r_hready;
  logic      r_hresp;

  // Outputs are registered alongside the state so they never glitch.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= DS_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      case (r_state)
        DS_IDLE: begin
          if (hready && i_err_req) begin
            r_state  <= DS_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          r_state  <= DS_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (hready && i_err_req) begin
            r_state  <= DS_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
          end else begin
            r_state  <= DS_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end
        end
        default: begin
          r_state  <= DS_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign o_hready = r_hready;
  assign o_hresp  = r_hresp;
  assign o_state  = r_state;

endmodule

// File: rtl/ahb_slave_mux_n.sv
// AHB-Lite address decoder and response multiplexer for NUM_SLAVES slaves,
// with a built-in default slave covering unmapped regions.
module ahb_slave_mux_n
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 4
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [ADDR_W-1:0]          haddr,
  input  logic [1:0]                 htrans,
  input  logic [NUM_SLAVES-1:0]      hreadyout_s,
  input  logic [NUM_SLAVES-1:0]      hresp_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  output logic [NUM_SLAVES-1:0]      hsel,
  output logic                       hready,
  output logic                       hresp,
  output logic [DATA_W-1:0]          hrdata,
  output ds_state_t                  o_dbg_state,
  output logic                       o_dbg_dsel_def
);

  localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W+1)'(NUM_SLAVES);

  logic [SEL_W-1:0] w_region;
  logic             w_mapped;
  logic             w_err_req;
  logic             w_ds_hready;
  logic             w_ds_hresp;
  logic             w_unused_bits;

  logic             r_dsel_def;
  logic [SEL_W-1:0] r_dsel_idx;

  assign w_region      = haddr[ADDR_W-1 -: SEL_W];
  assign w_mapped      = ({1'b0, w_region} < NUM_SLAVES_W);
  assign w_err_req     = !w_mapped && htrans[1];
  assign w_unused_bits = ^{haddr[ADDR_W-SEL_W-1:0], htrans[0]};

  // Address-phase decode is purely combinational and ignores htrans.
  always_comb begin
    hsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel[i] = w_mapped && (w_region == i[SEL_W-1:0]);
    end
  end

  // Data-phase owner only advances when the current transfer completes.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_dsel_def <= 1'b1;
      r_dsel_idx <= '0;
    end else if (hready) begin
      r_dsel_def <= !w_mapped;
      r_dsel_idx <= w_mapped ? w_region : '0;
    end
  end

  ahb_default_slave u_default (
    .hclk      (hclk),
    .hreset    (hreset),
    .hready    (hready),
    .i_err_req (w_err_req),
    .o_hready  (w_ds_hready),
    .o_hresp   (w_ds_hresp),
    .o_state   (o_dbg_state)
  );

  always_comb begin
    hrdata = '0;
    hready = w_ds_hready;
    hresp  = w_ds_hresp;
    if (!r_dsel_def) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (r_dsel_idx == i[SEL_W-1:0]) begin
          hrdata = hrdata_s[i*DATA_W +: DATA_W];
          hready = hreadyout_s[i];
          hresp  = hresp_s[i];
        end
      end
    end
  end

  assign o_dbg_dsel_def = r_dsel_def;

endmodule
